inst_loader: RTL and testbench

Boot-time program loader: the writer for the instruction memory that the pipeline's IF stage reads. It accepts a byte stream over a valid/ready handshake and packs the bytes big-endian into 32-bit words. It writes those words into INSTMEM through the memory's write port and holds the CPU core in reset until the image has loaded and passed its checks.

---
 rtl/inst_loader_pkg.sv | 18 +
 rtl/inst_loader_byte_packer.sv | 44 ++++
 rtl/inst_loader.sv | 156 +++++++++++++++
 tb/tb_inst_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
// Holds loader FSM states, image capacity and word size.
package inst_loader_pkg;

    localparam int DEF_ADDR_W    = 9;
    localparam int DEF_MAX_WORDS = 128;
    localparam int WORD_BYTES    = 4;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Packs accepted stream bytes MSB-first into 32-bit words.
// Ports: clk, rst_n (sync), clr, byte_valid/byte_data in; word_end, word, word_valid out.
module inst_loader_byte_packer
    import inst_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_end,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt;
    logic [23:0] sh;

    // High while the next accepted byte completes a word.
    assign word_end = (cnt == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            sh         <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clr) begin
                cnt <= '0;
                sh  <= '0;
            end else if (byte_valid) begin
                sh  <= {sh[15:0], byte_data};
                cnt <= cnt + 2'd1;
                if (word_end) begin
                    word       <= {sh, byte_data};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Boot loader: byte stream -> INSTMEM words, holds the core in reset until loaded.
// Ports: clk, rst_n, in_valid/in_data/in_ready, reload; im_wren/im_wraddr/im_wrdata,
// cpu_rst_n, done, err. Trailing XOR checksum byte enabled by LOADER_CSUM_EN.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              im_wren,
    output logic [ADDR_W-1:0] im_wraddr,
    output logic [31:0]       im_wrdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err
);

    localparam int KW = ADDR_W - 2;

    state_t        state;
    logic [7:0]    len_hi;
    logic [KW-1:0] k;
    logic [KW-1:0] n_last;
    logic          fire;
    logic [15:0]   n_len;
    logic          pk_valid;
    logic          pk_clr;
    logic          word_end;
`ifdef LOADER_CSUM_EN
    logic [7:0]    csum;
`endif

    assign fire   = in_valid && in_ready;
    assign n_len  = {len_hi, in_data};
    assign pk_valid = fire && (state == DATA);
    assign pk_clr = reload && ((state == DONE) || (state == ERR));

    inst_loader_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (pk_clr),
        .byte_valid (pk_valid),
        .byte_data  (in_data),
        .word_end   (word_end),
        .word       (im_wrdata),
        .word_valid (im_wren)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= LEN_HI;
            len_hi    <= '0;
            k         <= '0;
            n_last    <= '0;
            im_wraddr <= '0;
            in_ready  <= 1'b0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef LOADER_CSUM_EN
            csum      <= '0;
`endif
        end else begin
            unique case (state)
                LEN_HI: begin
                    in_ready <= 1'b1;
                    if (fire) begin
                        len_hi <= in_data;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (fire) begin
                        n_last <= KW'(n_len - 16'd1);
                        if (n_len > 16'(MAX_WORDS)) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (n_len == 16'd0) begin
`ifdef LOADER_CSUM_EN
                            state     <= CSUM;
`else
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                            in_ready  <= 1'b0;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (fire) begin
`ifdef LOADER_CSUM_EN
                        csum <= csum ^ in_data;
`endif
                        if (word_end) begin
                            im_wraddr <= {k, 2'b00};
                            k         <= k + 1'b1;
                            if (k == n_last) begin
`ifdef LOADER_CSUM_EN
                                state     <= CSUM;
`else
                                state     <= DONE;
                                done      <= 1'b1;
                                cpu_rst_n <= 1'b1;
                                in_ready  <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef LOADER_CSUM_EN
                CSUM: begin
                    if (fire) begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                DONE, ERR: begin
                    if (reload) begin
                        state     <= LEN_HI;
                        k         <= '0;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        cpu_rst_n <= 1'b0;
                        in_ready  <= 1'b1;
`ifdef LOADER_CSUM_EN
                        csum      <= '0;
`endif
                    end
                end
                default: begin
                    state    <= LEN_HI;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized self-checking bench for inst_loader.
// Reference: byte-stream builder plus a queue of expected INSTMEM writes.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        reload;
    logic        im_wren;
    logic [8:0]  im_wraddr;
    logic [31:0] im_wrdata;
    logic        cpu_rst_n;
    logic        done;
    logic        err;

    inst_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .reload    (reload),
        .im_wren   (im_wren),
        .im_wraddr (im_wraddr),
        .im_wrdata (im_wrdata),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [40:0] exp_q[$];
    logic [31:0] wq[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Every write must match the next expected (addr, data) pair.
    always @(negedge clk) begin
        if (im_wren === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexp_wr", 32'(im_wraddr), 32'hFFFF_FFFF);
            end else begin
                logic [40:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(im_wraddr), 32'(e[40:32]));
                chk("wr_data", im_wrdata, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("rdy_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Random idle gap; reload pulses here fall mid-load and must be ignored.
    task automatic idle(input int max);
        int g;
        g = $urandom_range(0, max);
        for (int i = 0; i < g; i++) begin
            reload = (max > 0) && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            reload = 1'b0;
        end
    endtask

    task automatic run_image(input int n, input int gap, input bit bad);
        logic [7:0]  x;
        logic [31:0] w;
        logic [15:0] nn;
        bit          ok;
        x  = 8'h00;
        nn = 16'(n);
        send_byte(nn[15:8]);
        idle(gap);
        send_byte(nn[7:0]);
        if (n > 128) begin
            chk("len_err", 32'(err), 32'd1);
            chk("len_cpu", 32'(cpu_rst_n), 32'd0);
            chk("len_rdy", 32'(in_ready), 32'd0);
            chk("len_done", 32'(done), 32'd0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = (wq.size() != 0) ? wq.pop_front() : $urandom;
            exp_q.push_back({9'(4 * i), w});
            for (int j = 0; j < 4; j++) begin
                x ^= w[31 - 8 * j -: 8];
                idle(gap);
                send_byte(w[31 - 8 * j -: 8]);
            end
        end
`ifdef LOADER_CSUM_EN
        idle(gap);
        send_byte(bad ? (x ^ 8'h01) : x);
        ok = !bad;
`else
        ok = 1'b1;
`endif
        chk("end_done", 32'(done), 32'(ok));
        chk("end_err", 32'(err), 32'(!ok));
        chk("end_cpu", 32'(cpu_rst_n), 32'(ok));
        chk("end_rdy", 32'(in_ready), 32'd0);
    endtask

    task automatic check_drained();
        @(negedge clk);
        chk("wr_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic refuse_bytes();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_rdy", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("rl_cpu", 32'(cpu_rst_n), 32'd0);
        chk("rl_done", 32'(done), 32'd0);
        chk("rl_err", 32'(err), 32'd0);
        chk("rl_rdy", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(in_ready), 32'd0);
        chk("rst_wren", 32'(im_wren), 32'd0);
        chk("rst_addr", 32'(im_wraddr), 32'd0);
        chk("rst_data", im_wrdata, 32'd0);
        chk("rst_cpu", 32'(cpu_rst_n), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_rise", 32'(in_ready), 32'd1);

        wq.push_back(32'h1122_3344);
        wq.push_back(32'h5566_7788);
        run_image(2, 0, 1'b0);
        check_drained();
        refuse_bytes();
        do_reload();

        wq.push_back(32'h1122_3344);
        wq.push_back(32'h5566_7788);
        run_image(2, 0, 1'b1);
        check_drained();
        do_reload();

        run_image(129, 2, 1'b0);
        check_drained();
        refuse_bytes();
        do_reload();

        run_image(128, 3, 1'b0);
        check_drained();
        do_reload();

        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_wren", 32'(im_wren), 32'd0);
        chk("mid_rdy", 32'(in_ready), 32'd0);
        chk("mid_data", im_wrdata, 32'd0);
        chk("mid_addr", 32'(im_wraddr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        wq.push_back(32'hDEAD_BEEF);
        run_image(1, 0, 1'b0);
        check_drained();
        do_reload();

        run_image(0, 1, 1'b0);
        check_drained();
        do_reload();

        for (int r = 0; r < 6; r++) begin
            run_image($urandom_range(1, 10), 2, bit'($urandom_range(0, 1)));
            check_drained();
            do_reload();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
